// File: rtl/led_display_pacer.sv
// -----------------------------------------------------------------------------
// led_display_pacer
//
// Purpose:
//   Read-side consumer of a clock-domain-crossing FIFO, running in the slow LED
//   clock domain. It pops one counter sample at a time and shows it on
//   active-low LEDs for HOLD_CYCLES clocks. It also checks that each sample is
//   the previous one plus 1 (mod 2^WIDTH), so a bad crossing shows up in
//   hardware as a sticky flag and a saturating error count.
//
// Ports:
//   clk           in   slow LED-domain clock
//   reset_button  in   asynchronous, active-low reset
//   fifo_empty    in   FIFO read-side empty flag
//   fifo_rd_en    out  FIFO pop strobe, high for the single READ cycle
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   leds          out  LED drive, active-low (0 lights the LED)
//   sample_valid  out  one-cycle pulse after a new sample is latched
//   seq_error     out  sticky: a non-consecutive sample was seen
//   error_count   out  saturating count of non-consecutive samples
//   state_dbg     out  current FSM state (0 IDLE, 1 READ, 2 CAPTURE, 3 HOLD)
//
// Handshake:
//   The pop decision is made only in IDLE, on the sampled fifo_empty. The FSM
//   then spends one cycle in READ with fifo_rd_en high and one cycle in
//   CAPTURE, where fifo_rd_data is valid. An empty FIFO is therefore never
//   popped, and a change of fifo_empty during READ has no effect.
// -----------------------------------------------------------------------------
module led_display_pacer #(
   parameter int WIDTH       = 6,
   parameter int HOLD_CYCLES = 4500000,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset_button,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic [WIDTH-1:0] leds,
   output logic             sample_valid,
   output logic             seq_error,
   output logic [CNT_W-1:0] error_count,
   output logic [1:0]       state_dbg
);

   localparam int HC_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
   localparam logic [HC_W-1:0]  HC_ONE    = {{(HC_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] DATA_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_CAPTURE = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic             first_q, first_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic             sample_valid_q, sample_valid_d;
   logic             seq_error_q, seq_error_d;
   logic [CNT_W-1:0] error_count_q, error_count_d;
   logic [WIDTH-1:0] prev_inc;
   logic             mismatch;

   // State register
   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         state_q        <= S_IDLE;
         hold_cnt_q     <= '0;
         first_q        <= 1'b1;
         prev_q         <= '0;
         leds_q         <= '1;
         sample_valid_q <= 1'b0;
         seq_error_q    <= 1'b0;
         error_count_q  <= '0;
      end else begin
         state_q        <= state_d;
         hold_cnt_q     <= hold_cnt_d;
         first_q        <= first_d;
         prev_q         <= prev_d;
         leds_q         <= leds_d;
         sample_valid_q <= sample_valid_d;
         seq_error_q    <= seq_error_d;
         error_count_q  <= error_count_d;
      end
   end

   // Next-state logic, including the display hold counter
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // Counting HOLD_CYCLES-1 down to 0 gives exactly HOLD_CYCLES
            // cycles in HOLD.
            hold_cnt_d = HOLD_LOAD;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - HC_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The increment stays WIDTH bits wide, so the wrap from all-ones to 0
   // counts as consecutive.
   always_comb begin
      prev_inc = prev_q + DATA_ONE;
      mismatch = !first_q && (fifo_rd_data != prev_inc);
   end

   // Sample capture and sequence check, active only in CAPTURE
   always_comb begin
      first_d        = first_q;
      prev_d         = prev_q;
      leds_d         = leds_q;
      sample_valid_d = 1'b0;
      seq_error_d    = seq_error_q;
      error_count_d  = error_count_q;
      if (state_q == S_CAPTURE) begin
         leds_d         = ~fifo_rd_data;
         prev_d         = fifo_rd_data;
         sample_valid_d = 1'b1;
         first_d        = 1'b0;
         if (mismatch) begin
            seq_error_d = 1'b1;
            if (error_count_q != CNT_MAX) begin
               error_count_d = error_count_q + CNT_ONE;
            end
         end
      end
   end

   // Outputs. fifo_rd_en is a pure decode of the state flops, so it cannot
   // glitch on input changes.
   always_comb begin
      fifo_rd_en   = (state_q == S_READ);
      leds         = leds_q;
      sample_valid = sample_valid_q;
      seq_error    = seq_error_q;
      error_count  = error_count_q;
      state_dbg    = state_q;
   end

endmodule

// File: tb/tb_led_display_pacer.sv
// -----------------------------------------------------------------------------
// tb_led_display_pacer
//
// Testbench for led_display_pacer. It builds two instances that differ only
// in CNT_W (8 and 2). Both share one FIFO model. The sel input picks which
// instance sees a non-empty FIFO and which one the monitor observes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_display_pacer;

   localparam int W = 6;
   localparam int H = 4;

   // Clock and reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_button;

   // FIFO model
   logic       sel;
   logic       hold_empty;
   logic [5:0] mem [64];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic [5:0] fifo_rd_data = 6'h00;
   logic       fifo_none;
   logic       empty_a, empty_b;

   logic       rd_en_a, rd_en_b;
   logic [5:0] leds_a, leds_b;
   logic       sv_a, sv_b, se_a, se_b;
   logic [7:0] ec_a;
   logic [1:0] ec_b;
   logic [1:0] st_a, st_b;

   assign fifo_none = hold_empty || (rd_ptr == wr_ptr);
   assign empty_a   = sel || fifo_none;
   assign empty_b   = !sel || fifo_none;

   always @(posedge clk) begin
      if (rd_en_a || rd_en_b) begin
         fifo_rd_data <= mem[rd_ptr[5:0]];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   led_display_pacer #(.WIDTH(W), .HOLD_CYCLES(H), .CNT_W(8)) dut (
      .clk(clk), .reset_button(reset_button), .fifo_empty(empty_a),
      .fifo_rd_en(rd_en_a), .fifo_rd_data(fifo_rd_data), .leds(leds_a),
      .sample_valid(sv_a), .seq_error(se_a), .error_count(ec_a),
      .state_dbg(st_a)
   );

   led_display_pacer #(.WIDTH(W), .HOLD_CYCLES(H), .CNT_W(2)) dut_sat (
      .clk(clk), .reset_button(reset_button), .fifo_empty(empty_b),
      .fifo_rd_en(rd_en_b), .fifo_rd_data(fifo_rd_data), .leds(leds_b),
      .sample_valid(sv_b), .seq_error(se_b), .error_count(ec_b),
      .state_dbg(st_b)
   );

   // Outputs of the instance under observation
   logic       m_rd_en, m_sv, m_se;
   logic [5:0] m_leds;
   logic [7:0] m_ec;
   logic [1:0] m_st;
   assign m_rd_en = sel ? rd_en_b : rd_en_a;
   assign m_sv    = sel ? sv_b : sv_a;
   assign m_se    = sel ? se_b : se_a;
   assign m_leds  = sel ? leds_b : leds_a;
   assign m_ec    = sel ? {6'b0, ec_b} : ec_a;
   assign m_st    = sel ? st_b : st_a;

   // Monitor: records on the falling edge. Only this process writes these
   // queues.
   int         cyc = 0;
   int         pop_t[$];
   int         sv_t[$];
   logic [5:0] sv_leds[$];
   logic       sv_err[$];
   logic [7:0] sv_cnt[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (m_rd_en) pop_t.push_back(cyc);
      if (m_sv) begin
         sv_t.push_back(cyc);
         sv_leds.push_back(m_leds);
         sv_err.push_back(m_se);
         sv_cnt.push_back(m_ec);
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   // Driver tasks
   task automatic push(input logic [5:0] v);
      mem[wr_ptr[5:0]] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset_button = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      reset_button = 1'b1;
   endtask

   task automatic wait_samples(input int target, output bit ok);
      for (int i = 0; i < 300; i++) begin
         if (sv_t.size() >= target) break;
         @(negedge clk); #1;
      end
      ok = (sv_t.size() >= target);
   endtask

   // Tests
   task automatic test_reset();
      bit ok;
      int sb;
      repeat (2) @(negedge clk);
      #1;
      n_total++; if (m_leds !== 6'h3F) $display("FAIL reset_leds: got %h want 3f", m_leds); else n_pass++;
      n_total++; if (m_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", m_rd_en); else n_pass++;
      n_total++; if (m_sv !== 1'b0) $display("FAIL reset_sv: got %b want 0", m_sv); else n_pass++;
      n_total++; if (m_se !== 1'b0) $display("FAIL reset_se: got %b want 0", m_se); else n_pass++;
      n_total++; if (m_ec !== 8'd0) $display("FAIL reset_ec: got %0d want 0", m_ec); else n_pass++;
      n_total++; if (m_st !== 2'd0) $display("FAIL reset_state: got %0d want 0", m_st); else n_pass++;
      reset_button = 1'b1;
      // Latch one word, then assert reset between edges.
      sb = sv_t.size();
      push(6'h2A);
      wait_samples(sb + 1, ok);
      n_total++; if (!ok) $display("FAIL reset_word_timeout: got %0d samples want %0d", sv_t.size() - sb, 1); else n_pass++;
      n_total++; if (m_leds !== 6'h15) $display("FAIL reset_word_leds: got %h want 15", m_leds); else n_pass++;
      #2;
      reset_button = 1'b0;
      #1;
      n_total++; if (m_leds !== 6'h3F) $display("FAIL async_leds: got %h want 3f", m_leds); else n_pass++;
      n_total++; if (m_sv !== 1'b0) $display("FAIL async_sv: got %b want 0", m_sv); else n_pass++;
      n_total++; if (m_st !== 2'd0) $display("FAIL async_state: got %0d want 0", m_st); else n_pass++;
      @(negedge clk); #1;
      reset_button = 1'b1;
   endtask

   task automatic test_sequence();
      bit ok;
      int pb, sb;
      logic [5:0] exp_q[$];
      do_reset();
      pb = pop_t.size();
      sb = sv_t.size();
      exp_q = '{6'h3F, 6'h3E, 6'h3D};
      push(6'd0); push(6'd1); push(6'd2);
      wait_samples(sb + 3, ok);
      n_total++; if (!ok) $display("FAIL seq_timeout: got %0d samples want 3", sv_t.size() - sb); else n_pass++;
      n_total++; if (pop_t.size() - pb !== 3) $display("FAIL seq_pop_count: got %0d want 3", pop_t.size() - pb); else n_pass++;
      if (ok && pop_t.size() - pb == 3) begin
         for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
               n_total++;
               if (pop_t[pb+i] - pop_t[pb+i-1] !== 7) $display("FAIL seq_pop_spacing%0d: got %0d want 7", i, pop_t[pb+i] - pop_t[pb+i-1]); else n_pass++;
            end
            n_total++;
            if (sv_t[sb+i] - pop_t[pb+i] !== 2) $display("FAIL seq_latency%0d: got %0d want 2", i, sv_t[sb+i] - pop_t[pb+i]); else n_pass++;
            n_total++;
            if (sv_leds[sb+i] !== exp_q[i]) $display("FAIL seq_leds%0d: got %h want %h", i, sv_leds[sb+i], exp_q[i]); else n_pass++;
         end
      end
      n_total++; if (m_se !== 1'b0) $display("FAIL seq_error_flag: got %b want 0", m_se); else n_pass++;
   endtask

   // Runs one word list and compares LEDs, flag and count seen at each sample
   task automatic test_gap();
      bit ok;
      int sb;
      logic [5:0] exp_q[$];
      logic       exp_err[$];
      logic [7:0] exp_cnt[$];
      do_reset();
      sb = sv_t.size();
      exp_q   = '{6'h3A, 6'h39, 6'h36, 6'h35};
      exp_err = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd1};
      push(6'd5); push(6'd6); push(6'd9); push(6'd10);
      wait_samples(sb + 4, ok);
      n_total++; if (!ok) $display("FAIL gap_timeout: got %0d samples want 4", sv_t.size() - sb); else n_pass++;
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            n_total++; if (sv_leds[sb+i] !== exp_q[i]) $display("FAIL gap_leds%0d: got %h want %h", i, sv_leds[sb+i], exp_q[i]); else n_pass++;
            n_total++; if (sv_err[sb+i] !== exp_err[i]) $display("FAIL gap_err%0d: got %b want %b", i, sv_err[sb+i], exp_err[i]); else n_pass++;
            n_total++; if (sv_cnt[sb+i] !== exp_cnt[i]) $display("FAIL gap_cnt%0d: got %0d want %0d", i, sv_cnt[sb+i], exp_cnt[i]); else n_pass++;
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int sb;
      logic [5:0] exp_q[$];
      do_reset();
      sb = sv_t.size();
      exp_q = '{6'h01, 6'h00, 6'h3F, 6'h3E};
      push(6'd62); push(6'd63); push(6'd0); push(6'd1);
      wait_samples(sb + 4, ok);
      n_total++; if (!ok) $display("FAIL wrap_timeout: got %0d samples want 4", sv_t.size() - sb); else n_pass++;
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            n_total++; if (sv_leds[sb+i] !== exp_q[i]) $display("FAIL wrap_leds%0d: got %h want %h", i, sv_leds[sb+i], exp_q[i]); else n_pass++;
         end
      end
      n_total++; if (m_se !== 1'b0) $display("FAIL wrap_se: got %b want 0", m_se); else n_pass++;
      n_total++; if (m_ec !== 8'd0) $display("FAIL wrap_ec: got %0d want 0", m_ec); else n_pass++;
   endtask

   task automatic test_empty_hold();
      bit ok;
      int sb, pb, c;
      do_reset();
      sb = sv_t.size();
      push(6'd7);
      wait_samples(sb + 1, ok);
      n_total++; if (!ok) $display("FAIL empty_first_timeout: got %0d samples want 1", sv_t.size() - sb); else n_pass++;
      hold_empty = 1'b1;
      push(6'd8);
      pb = pop_t.size();
      repeat (100) @(negedge clk);
      #1;
      n_total++; if (pop_t.size() !== pb) $display("FAIL empty_no_pop: got %0d pops want 0", pop_t.size() - pb); else n_pass++;
      n_total++; if (m_leds !== 6'h38) $display("FAIL empty_leds: got %h want 38", m_leds); else n_pass++;
      n_total++; if (m_st !== 2'd0) $display("FAIL empty_state: got %0d want 0", m_st); else n_pass++;
      c = cyc;
      hold_empty = 1'b0;
      @(negedge clk); #1;
      n_total++; if (pop_t.size() !== pb + 1) $display("FAIL empty_release_pop: got %0d pops want 1", pop_t.size() - pb); else n_pass++;
      if (pop_t.size() > pb) begin
         n_total++; if (pop_t[pb] !== c + 1) $display("FAIL empty_release_time: got %0d want %0d", pop_t[pb], c + 1); else n_pass++;
      end
      wait_samples(sb + 2, ok);
      n_total++; if (!ok || sv_leds[sb+1] !== 6'h37) $display("FAIL empty_next_leds: got %h want 37", m_leds); else n_pass++;
      n_total++; if (m_se !== 1'b0) $display("FAIL empty_se: got %b want 0", m_se); else n_pass++;
   endtask

   task automatic test_saturate();
      bit ok;
      int sb;
      logic       exp_err[$];
      logic [7:0] exp_cnt[$];
      sel = 1'b1;
      do_reset();
      sb = sv_t.size();
      exp_err = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_cnt = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
      push(6'd0); push(6'd2); push(6'd4); push(6'd6); push(6'd8); push(6'd10);
      wait_samples(sb + 6, ok);
      n_total++; if (!ok) $display("FAIL sat_timeout: got %0d samples want 6", sv_t.size() - sb); else n_pass++;
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_total++; if (sv_err[sb+i] !== exp_err[i]) $display("FAIL sat_err%0d: got %b want %b", i, sv_err[sb+i], exp_err[i]); else n_pass++;
            n_total++; if (sv_cnt[sb+i] !== exp_cnt[i]) $display("FAIL sat_cnt%0d: got %0d want %0d", i, sv_cnt[sb+i], exp_cnt[i]); else n_pass++;
         end
      end
      // The design is now in HOLD with the last word displayed.
      n_total++; if (m_st !== 2'd3) $display("FAIL sat_in_hold: got %0d want 3", m_st); else n_pass++;
      #2;
      reset_button = 1'b0;
      #1;
      n_total++; if (m_ec !== 8'd0) $display("FAIL sat_reset_ec: got %0d want 0", m_ec); else n_pass++;
      n_total++; if (m_se !== 1'b0) $display("FAIL sat_reset_se: got %b want 0", m_se); else n_pass++;
      @(negedge clk); #1;
      reset_button = 1'b1;
      sb = sv_t.size();
      push(6'd20); push(6'd21);
      wait_samples(sb + 2, ok);
      n_total++; if (!ok) $display("FAIL post_timeout: got %0d samples want 2", sv_t.size() - sb); else n_pass++;
      if (ok) begin
         n_total++; if (sv_leds[sb] !== 6'h2B) $display("FAIL post_leds0: got %h want 2b", sv_leds[sb]); else n_pass++;
         n_total++; if (sv_leds[sb+1] !== 6'h2A) $display("FAIL post_leds1: got %h want 2a", sv_leds[sb+1]); else n_pass++;
         n_total++; if (sv_err[sb] !== 1'b0) $display("FAIL post_err0: got %b want 0", sv_err[sb]); else n_pass++;
         n_total++; if (sv_cnt[sb+1] !== 8'd0) $display("FAIL post_cnt1: got %0d want 0", sv_cnt[sb+1]); else n_pass++;
      end
      n_total++; if (m_se !== 1'b0) $display("FAIL post_se: got %b want 0", m_se); else n_pass++;
   endtask

   initial begin
      reset_button = 1'b0;
      sel          = 1'b0;
      hold_empty   = 1'b0;
      test_reset();
      test_sequence();
      test_gap();
      test_wrap();
      test_empty_hold();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
